// File: rtl/enc_pri_rr.sv
// enc_pri_rr: registered N-to-W priority encoder with a 1-deep ready/valid
// output register.
//
// Each load cycle the request lines are turned into a single granted index.
// Arbitration is either fixed priority (index 0 highest) or round-robin
// from a rotating pointer. Input polarity is selectable.
//
// Parameters:
//   N          number of request inputs (2..64)
//   W          index width, derived from N
//   ACTIVE_LOW 1 = a request bit is asserted when its input is 0
//   RR_MODE    0 = fixed priority, 1 = round-robin
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        raw request lines, sampled only in load cycles
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx/out_multi hold a valid encode
//   out_idx    index of the granted request
//   out_multi  more than one request was active when out_idx was loaded
//   rr_ptr     round-robin pointer (debug); stays 0 in fixed-priority mode
module enc_pri_rr #(
  parameter int N          = 8,
  parameter int W          = $clog2(N),
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit RR_MODE    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi,
  output logic [W-1:0] rr_ptr
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [N-1:0] act;
  logic         load;
  logic         accept;
  logic         any_act;
  logic         multi_act;
  logic [W-1:0] p;
  logic [W-1:0] sel;

  // Increment an index modulo N; also correct when N is not a power of two.
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    if (v == W'(N - 1)) begin
      return '0;
    end else begin
      return v + W'(1);
    end
  endfunction

  assign act       = ACTIVE_LOW ? ~req : req;
  assign load      = !valid_q || out_ready;
  assign accept    = valid_q && out_ready;
  assign any_act   = |act;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_act = |(act & (act - ONE_N));

  // When a transfer completes in the same cycle as a new load, the search
  // must start just past the index being handed off, not at the stale
  // pointer, or the same requester could win twice in a row.
  always_comb begin
    p = '0;
    if (RR_MODE) begin
      p = accept ? wrap_inc(idx_q) : ptr_q;
    end
  end

  // Circular search starting at p; with p=0 this is plain lowest-index-first.
  always_comb begin
    int  j;
    logic found;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(p) + i;
      if (j >= N) begin
        j = j - N;
      end
      if (!found && act[j]) begin
        found = 1'b1;
        sel   = W'(j);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = any_act;
      if (any_act) begin
        idx_d   = sel;
        multi_d = multi_act;
      end
    end
    if (RR_MODE && accept) begin
      ptr_d = wrap_inc(idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_multi = multi_q;
  assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_enc_pri_rr.sv
// Bench for enc_pri_rr: four instances (fixed/active-high, fixed/active-low,
// round-robin N=8, round-robin N=6). Stimulus pushes expected grants into a
// per-instance queue; per-instance monitors pop and compare on each transfer.
module tb_enc_pri_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected transfer: {rr_ptr, out_multi, out_idx}
  typedef logic [16:0] ent_t;
  ent_t qA[$];
  ent_t qB[$];
  ent_t qC[$];
  ent_t qD[$];

  logic [7:0] reqA, reqB, reqC;
  logic [5:0] reqD;
  logic       rdyA, rdyB, rdyC, rdyD;
  logic       vA, vB, vC, vD;
  logic       mA, mB, mC, mD;
  logic [2:0] idxA, idxB, idxC, idxD;
  logic [2:0] pA, pB, pC, pD;

  enc_pri_rr #(.N(8), .ACTIVE_LOW(1'b0), .RR_MODE(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .req(reqA), .out_ready(rdyA),
    .out_valid(vA), .out_idx(idxA), .out_multi(mA), .rr_ptr(pA));
  enc_pri_rr #(.N(8), .ACTIVE_LOW(1'b1), .RR_MODE(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .req(reqB), .out_ready(rdyB),
    .out_valid(vB), .out_idx(idxB), .out_multi(mB), .rr_ptr(pB));
  enc_pri_rr #(.N(8), .ACTIVE_LOW(1'b0), .RR_MODE(1'b1)) dutC (
    .clk(clk), .rst_n(rst_n), .req(reqC), .out_ready(rdyC),
    .out_valid(vC), .out_idx(idxC), .out_multi(mC), .rr_ptr(pC));
  enc_pri_rr #(.N(6), .ACTIVE_LOW(1'b0), .RR_MODE(1'b1)) dutD (
    .clk(clk), .rst_n(rst_n), .req(reqD), .out_ready(rdyD),
    .out_valid(vD), .out_idx(idxD), .out_multi(mD), .rr_ptr(pD));

  function automatic ent_t mk(input int p, input int m, input int i);
    return {8'(p), 1'(m), 8'(i)};
  endfunction

  task automatic chk_ent(input string name, input ent_t act, input ent_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ptr=%0d multi=%0d idx=%0d, want ptr=%0d multi=%0d idx=%0d",
               name, act[16:9], act[8], act[7:0], exp[16:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitors: one per instance, comparing on every accepted transfer.
  always @(negedge clk) begin
    if (rst_n && vA && rdyA) begin
      if (qA.size() == 0) chk_ent("A unexpected xfer", mk(pA, mA, idxA), '1);
      else chk_ent("A xfer", mk(pA, mA, idxA), qA.pop_front());
    end
  end
  always @(negedge clk) begin
    if (rst_n && vB && rdyB) begin
      if (qB.size() == 0) chk_ent("B unexpected xfer", mk(pB, mB, idxB), '1);
      else chk_ent("B xfer", mk(pB, mB, idxB), qB.pop_front());
    end
  end
  always @(negedge clk) begin
    if (rst_n && vC && rdyC) begin
      if (qC.size() == 0) chk_ent("C unexpected xfer", mk(pC, mC, idxC), '1);
      else chk_ent("C xfer", mk(pC, mC, idxC), qC.pop_front());
    end
  end
  always @(negedge clk) begin
    if (rst_n && vD && rdyD) begin
      if (qD.size() == 0) chk_ent("D unexpected xfer", mk(pD, mD, idxD), '1);
      else chk_ent("D xfer", mk(pD, mD, idxD), qD.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reqA = 8'h00; reqB = 8'hFF; reqC = 8'h00; reqD = 6'h00;
    rdyA = 1'b0; rdyB = 1'b0; rdyC = 1'b0; rdyD = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("reset A valid", vA, 0);
    chk("reset A idx", idxA, 0);
    chk("reset A multi", mA, 0);
    chk("reset C ptr", pC, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle A valid", vA, 0);

    // One-hot sweep, fixed priority
    rdyA = 1'b1;
    for (int k = 0; k < 8; k++) begin
      reqA = 8'h01 << k;
      qA.push_back(mk(0, 0, k));
      tick();
    end
    reqA = 8'h00;
    tick();
    chk("A empty load valid", vA, 0);
    chk("A empty load idx hold", idxA, 7);

    // Collision
    reqA = 8'hA4;
    qA.push_back(mk(0, 1, 2));
    tick();
    reqA = 8'h00;
    tick();

    // Backpressure: req changes while held must be ignored
    reqA = 8'h10;
    qA.push_back(mk(0, 0, 4));
    tick();
    rdyA = 1'b0;
    reqA = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("A hold valid", vA, 1);
      chk("A hold idx", idxA, 4);
    end
    rdyA = 1'b1;
    qA.push_back(mk(0, 0, 0));
    tick();
    reqA = 8'h00;
    tick();
    chk("A after bp valid", vA, 0);
    rdyA = 1'b0;

    // Active-low polarity
    rdyB = 1'b1;
    reqB = 8'hF7;
    qB.push_back(mk(0, 0, 3));
    tick();
    reqB = 8'h5B;
    qB.push_back(mk(0, 1, 2));
    tick();
    reqB = 8'hFF;
    tick();
    chk("B all-high idle valid", vB, 0);
    rdyB = 1'b0;

    // Round-robin fairness N=8, then a lone request with a nonzero pointer
    rdyC = 1'b1;
    reqC = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      qC.push_back(mk(k % 8, 1, k % 8));
      tick();
    end
    reqC = 8'h01;
    qC.push_back(mk(2, 0, 0));
    tick();
    reqC = 8'h00;
    tick();
    chk("C idle valid", vC, 0);
    chk("C ptr after last xfer", pC, 1);
    rdyC = 1'b0;

    // Round-robin skip, N=6
    rdyD = 1'b1;
    reqD = 6'b100001;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) qD.push_back(mk(0, 1, 0));
      else qD.push_back(mk(1, 1, 5));
      tick();
    end
    reqD = 6'h00;
    tick();
    chk("D idle valid", vD, 0);
    rdyD = 1'b0;

    // Asynchronous reset while holding a valid grant
    rdyA = 1'b1;
    reqA = 8'h08;
    tick();
    rdyA = 1'b0;
    reqA = 8'h00;
    chk("A pre-reset valid", vA, 1);
    chk("A pre-reset idx", idxA, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", vA, 0);
    chk("async reset idx", idxA, 0);
    chk("async reset multi", mA, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-reset idle valid", vA, 0);

    chk("A queue drained", qA.size(), 0);
    chk("B queue drained", qB.size(), 0);
    chk("C queue drained", qC.size(), 0);
    chk("D queue drained", qD.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_pri_rr.md
Name: enc_pri_rr

Overview:
- Parametrised, registered N-to-log2(N) priority encoder: successor to the fixed 4:2 active-high/active-low encoders.
- Adds selectable input polarity, fixed-priority or round-robin arbitration, a "multiple requests" flag, and a 1-deep ready/valid output register with backpressure.
- Used wherever several request lines must be turned into a single granted index per cycle, e.g. interrupt or channel selection.

Parameters:
N, 8, number of request inputs; legal range 2..64.
W, ($clog2(N)), index width; derived, not overridden.
ACTIVE_LOW, 0, 1 = request bit asserted when input is 0; 0 = asserted when 1.
RR_MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin starting from rotating pointer.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N  raw request lines; polarity per ACTIVE_LOW; sampled only in load cycles.
out_ready  input  1  consumer accepts out_idx this cycle.
out_valid  output  1  out_idx/out_multi hold a valid encode.
out_idx  output  W  index of granted request.
out_multi  output  1  more than one request was active when out_idx was loaded.
rr_ptr  output  W  current round-robin pointer; debug only, stays 0 when RR_MODE=0.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_idx=0, out_multi=0, rr_ptr=0. Takes effect immediately, mid-transfer included. Release is synchronous to the next clk edge.
- Request mask: act = ACTIVE_LOW ? ~req : req.
- Load condition: load = !out_valid || out_ready.
- On a load edge:
  - act != 0 -> out_valid<=1, out_idx<=sel, out_multi<=(popcount(act)>1).
  - act == 0 -> out_valid<=0; out_idx and out_multi hold their previous values.
- When not loading (out_valid=1, out_ready=0): all outputs hold and req is ignored, even if it changes.
- Latency: req to out_valid/out_idx is 1 clk. Full throughput, one grant per cycle, while out_ready=1.
- Fixed priority (RR_MODE=0): sel = lowest set index of act.
- Round-robin (RR_MODE=1):
  - Effective pointer p = (out_valid && out_ready) ? (out_idx+1 mod N) : rr_ptr.
  - sel = first set bit of act searching p, p+1, ..., N-1, 0, ..., p-1.
  - On every accepted transfer (out_valid && out_ready), rr_ptr <= out_idx+1, wrapping N-1 -> 0 (also correct for non-power-of-2 N).
  - rr_ptr is unchanged when no transfer occurs.
  - Simultaneous accept and load must use p, not the stale rr_ptr, so the same index is never granted twice in a row while others are requesting.
- A single active request is always granted regardless of mode or pointer.
- Index width: W bits. For non-power-of-2 N, index values >= N never appear.
- No X propagation: out_idx is defined from reset onward.

Test Plan:
- Reset/idle: N=8, assert rst_n=0 mid-run with out_valid=1 -> outputs go 0 before the next clk edge. Release with req=0 -> out_valid stays 0.
- One-hot sweep, fixed priority: drive req=1<<k for k=0..7 with out_ready=1 -> one cycle later out_idx=k, out_valid=1, out_multi=0.
- Fixed-priority collision: req=8'b1010_0100, out_ready=1 -> out_idx=2, out_multi=1. With ACTIVE_LOW=1 and req=8'b1111_0111 -> out_idx=3, out_multi=0.
- Backpressure: load req=8'h10 then hold out_ready=0 for 3 cycles while req changes to 8'h01 -> out_idx stays 4, out_valid=1. Raise out_ready -> next cycle out_idx=0.
- Round-robin fairness: RR_MODE=1, req=8'hFF held, out_ready=1 -> out_idx sequence 0,1,2,...,7,0 with no repeats; rr_ptr wraps 7->0.
- Round-robin skip with N=6: req=6'b100001, ptr after granting 0 -> next grant 5, then 0, alternating; out_multi=1 throughout.
